// File: rtl/audio_pkg.sv
// Shared widths, arbiter state encoding and grant codes for the SRAM arbiter slice.
package audio_pkg;
   localparam int ADDR_W = 20;
   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_READ  = 2'd2,
      S_DONE  = 2'd3
   } arb_state_t;

   // Grant codes: bit 0 is the recorder (write), bit 1 the player (read).
   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_WR   = 2'b01;
   localparam logic [1:0] GNT_RD   = 2'b10;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module rr_arbiter2
   import audio_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [1:0] i_req,
   input  logic       i_advance,
   output logic [1:0] o_grant
);

   logic r_last_rd;

   // Grant decode from pending requests and last-grant history.
   always_comb begin
      o_grant = GNT_NONE;
      case (i_req)
         2'b01: o_grant = GNT_WR;
         2'b10: o_grant = GNT_RD;
         2'b11: begin
            if (r_last_rd) begin
               o_grant = GNT_WR;
            end else begin
               o_grant = GNT_RD;
            end
         end
         default: o_grant = GNT_NONE;
      endcase
   end

   // Last-grant register; resets to "read" so the write side wins the first tie.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_last_rd <= 1'b1;
      end else if (i_advance && (o_grant != GNT_NONE)) begin
         r_last_rd <= (o_grant == GNT_RD);
      end else begin
         r_last_rd <= r_last_rd;
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between a recorder (writes) and a player (reads).
// Every access is followed by one idle turnaround cycle; all pins are registered.
module sram_arbiter
   import audio_pkg::*;
#(
   parameter int WR_CYCLES = 2,
   parameter int RD_CYCLES = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_wr_req,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_wr_ack,
   input  logic              i_rd_req,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_rd_valid,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic [DATA_W-1:0] o_sram_dq,
   output logic              o_sram_dq_oe,
   input  logic [DATA_W-1:0] i_sram_dq,
   output logic              o_sram_ce_n,
   output logic              o_sram_we_n,
   output logic              o_sram_oe_n,
   output logic              o_sram_lb_n,
   output logic              o_sram_ub_n,
   output logic              o_busy
);

   localparam logic [2:0] WR_LAST = 3'(WR_CYCLES - 1);
   localparam logic [2:0] RD_LAST = 3'(RD_CYCLES - 1);

   arb_state_t        r_state;
   arb_state_t        w_next;
   logic [2:0]        r_cnt;
   logic [1:0]        w_grant;
   logic              w_advance;
   logic              w_wr_done;
   logic              w_rd_done;
   logic              w_access;
   logic [ADDR_W-1:0] r_sram_addr;
   logic [DATA_W-1:0] r_sram_dq;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_ce_n;
   logic              r_we_n;
   logic              r_oe_n;
   logic              r_lbub_n;
   logic              r_dq_oe;
   logic              r_wr_ack;
   logic              r_rd_valid;
   logic              r_busy;

   assign w_advance = (r_state == S_IDLE);

   rr_arbiter2 u_rr (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_req     ({i_rd_req, i_wr_req}),
      .i_advance (w_advance),
      .o_grant   (w_grant)
   );

   // Next-state logic; requests are only looked at in S_IDLE.
   always_comb begin
      w_next    = r_state;
      w_wr_done = 1'b0;
      w_rd_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_grant == GNT_WR) begin
               w_next = S_WRITE;
            end else if (w_grant == GNT_RD) begin
               w_next = S_READ;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_WRITE: begin
            if (r_cnt == WR_LAST) begin
               w_next    = S_DONE;
               w_wr_done = 1'b1;
            end else begin
               w_next = S_WRITE;
            end
         end
         S_READ: begin
            if (r_cnt == RD_LAST) begin
               w_next    = S_DONE;
               w_rd_done = 1'b1;
            end else begin
               w_next = S_READ;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   assign w_access = (w_next == S_WRITE) || (w_next == S_READ);

   // State, cycle counter and pins; strobes are decoded from the next state so
   // the registered pins line up with the state they belong to.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= 3'd0;
         r_sram_addr <= '0;
         r_sram_dq   <= '0;
         r_rd_data   <= '0;
         r_ce_n      <= 1'b1;
         r_we_n      <= 1'b1;
         r_oe_n      <= 1'b1;
         r_lbub_n    <= 1'b1;
         r_dq_oe     <= 1'b0;
         r_wr_ack    <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state) begin
            r_cnt <= 3'd0;
         end else if (w_access) begin
            r_cnt <= r_cnt + 3'd1;
         end else begin
            r_cnt <= 3'd0;
         end
         if (w_grant == GNT_WR && w_advance) begin
            r_sram_addr <= i_wr_addr;
            r_sram_dq   <= i_wr_data;
         end else if (w_grant == GNT_RD && w_advance) begin
            r_sram_addr <= i_rd_addr;
         end
         if (w_rd_done) begin
            r_rd_data <= i_sram_dq;
         end
         r_ce_n     <= ~w_access;
         r_lbub_n   <= ~w_access;
         r_we_n     <= ~(w_next == S_WRITE);
         r_oe_n     <= ~(w_next == S_READ);
         r_dq_oe    <= (w_next == S_WRITE);
         r_wr_ack   <= w_wr_done;
         r_rd_valid <= w_rd_done;
         r_busy     <= (w_next != S_IDLE);
      end
   end

   assign o_sram_addr  = r_sram_addr;
   assign o_sram_dq    = r_sram_dq;
   assign o_sram_dq_oe = r_dq_oe;
   assign o_sram_ce_n  = r_ce_n;
   assign o_sram_we_n  = r_we_n;
   assign o_sram_oe_n  = r_oe_n;
   assign o_sram_lb_n  = r_lbub_n;
   assign o_sram_ub_n  = r_lbub_n;
   assign o_rd_data    = r_rd_data;
   assign o_wr_ack     = r_wr_ack;
   assign o_rd_valid   = r_rd_valid;
   assign o_busy       = r_busy;

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter WR_CYCLES, 2, cycles the SRAM write strobe is held (1..7).
REQ-002 Parameter RD_CYCLES, 2, cycles the SRAM output enable is held before sampling (1..7).
REQ-003 i_clk  in  1  single clock; all logic on rising edge.
REQ-004 i_rst_n  in  1  reset, synchronous, active-low.
REQ-005 i_wr_req  in  1  recorder write request, held until ack.
REQ-006 i_wr_addr  in  20  write word address, held with request.
REQ-007 i_wr_data  in  16  write word, held with request.
REQ-008 o_wr_ack  out  1  one-cycle pulse: write committed.
REQ-009 i_rd_req  in  1  player read request, held until valid.
REQ-010 i_rd_addr  in  20  read word address, held with request.
REQ-011 o_rd_data  out  16  read word, registered, stable until next read completes.
REQ-012 o_rd_valid  out  1  one-cycle pulse: o_rd_data updated.
REQ-013 o_sram_addr  out  20  SRAM address.
REQ-014 o_sram_dq  out  16  SRAM write data.
REQ-015 o_sram_dq_oe  out  1  high drives the SRAM data bus.
REQ-016 i_sram_dq  in  16  SRAM read data.
REQ-017 o_sram_ce_n, o_sram_we_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n  out  1 each  active-low SRAM strobes.
REQ-018 o_busy  out  1  high whenever state is not S_IDLE.

Function
REQ-019 The FSM shall have states S_IDLE, S_WRITE, S_READ, S_DONE.
REQ-020 In S_IDLE, on a pending request, the FSM shall latch the granted address and data into registers and enter S_WRITE or S_READ on the next edge.
REQ-021 Both requests pending in S_IDLE shall be granted round-robin: the requester not granted last wins; a lone request is granted immediately.
REQ-022 S_WRITE shall last exactly WR_CYCLES cycles with ce_n=0, we_n=0, oe_n=1, dq_oe=1 and latched address/data on the SRAM pins, then go to S_DONE.
REQ-023 S_READ shall last exactly RD_CYCLES cycles with ce_n=0, oe_n=0, we_n=1, dq_oe=0; i_sram_dq shall be captured into o_rd_data at the edge leaving the final S_READ cycle.
REQ-024 S_DONE shall last one cycle with all strobes deasserted and dq_oe=0 (bus turnaround); o_wr_ack or o_rd_valid, per the completed access, shall be high only in this cycle; next state is S_IDLE.
REQ-025 Latency: a request first seen in S_IDLE at cycle t shall produce ack/valid at cycle t+WR_CYCLES+1 (write) or t+RD_CYCLES+1 (read).
REQ-026 Requesters drop req on the edge ending S_DONE; a request still high in S_IDLE after S_DONE shall be treated as a new request.
REQ-027 lb_n and ub_n shall be 0 during any access and 1 otherwise.
REQ-028 Request changes during S_WRITE/S_READ/S_DONE shall be ignored; accesses are never aborted.
REQ-029 we_n and oe_n shall never be low in the same cycle; dq_oe shall be 1 only in S_WRITE.

Reset
REQ-030 With i_rst_n low at a clock edge: state=S_IDLE; ce_n, we_n, oe_n, lb_n, ub_n=1; dq_oe=0; o_sram_addr=0; o_sram_dq=0; o_rd_data=0; ack/valid/busy=0; last-grant register = read, so write wins the first tie.
REQ-031 Reset asserted mid-access shall abandon the access without ack/valid and with no further strobe activity.

Structure
REQ-032 Package audio_pkg shall hold ADDR_W=20, DATA_W=16 and the arbiter state enum.
REQ-033 Two-way round-robin grant logic shall be sub-module rr_arbiter2 (req[1:0], advance strobe, grant one-hot, last-grant register).

Verification
REQ-034 Lone write 0x00005/0xBEEF, WR_CYCLES=2: we_n low for exactly 2 cycles with addr 0x00005 and dq 0xBEEF; o_wr_ack on the 3rd cycle after the request is first seen.
REQ-035 Lone read 0x00005 with SRAM model preloaded 0xBEEF: oe_n low 2 cycles, o_rd_valid with o_rd_data=0xBEEF 3 cycles after request.
REQ-036 Both requests held continuously from reset: grants alternate W,R,W,R; each access is followed by one turnaround cycle with all strobes high.
REQ-037 Recorder-style stream, 100 sequential writes from address 0: SRAM model contents match; we_n/oe_n never low together; dq_oe never 1 outside S_WRITE.
REQ-038 Reset pulsed in the 2nd S_WRITE cycle: next cycle all strobes high, dq_oe=0, no o_wr_ack; later requests complete normally.
REQ-039 WR_CYCLES=1 and RD_CYCLES=7: write ack at t+2, read valid at t+8.
